// File: rtl/twos_to_signmag_serial_if.sv
// Handshake bundle for the serial two's-complement to sign-magnitude converter.
// The slave modport faces the converter and the master modport faces the source/consumer.
interface twos_to_signmag_serial_if #(
  parameter int N = 5
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [N-1:0] out_mag;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_mag
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_mag
  );
endinterface

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first, one word in flight.
// Negative words use copy-until-first-one-then-invert; positive words pass through unchanged.
module twos_to_signmag_serial #(
  parameter int N = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  twos_to_signmag_serial_if.slave  io_bus
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_sr;
  logic [N-1:0]  r_mag;
  logic          r_sign;
  logic          r_seen;
  logic          r_out_valid;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_ob;
  logic          w_last;

  // Ready is combinational so a waiting word can be taken on the DONE cycle itself.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready = 1'b1;
      S_DONE:  w_in_ready = io_bus.out_ready;
      default: w_in_ready = 1'b0;
    endcase
  end

  // Output bit for this shift: invert only after the first one of a negative word.
  always_comb begin
    w_ob = r_sr[0];
    if (r_sign && r_seen) begin
      w_ob = ~r_sr[0];
    end else begin
      w_ob = r_sr[0];
    end
  end

  assign w_accept = io_bus.in_valid & w_in_ready;
  assign w_last   = (r_cnt == CW'(N - 1));

  // Sequencer and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_sr        <= {N{1'b0}};
      r_mag       <= {N{1'b0}};
      r_sign      <= 1'b0;
      r_seen      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_sr        <= io_bus.in_data;
      r_sign      <= io_bus.in_data[N-1];
      r_seen      <= 1'b0;
      r_cnt       <= {CW{1'b0}};
      r_out_valid <= 1'b0;
      r_state     <= S_SHIFT;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_out_valid <= 1'b0;
        end
        S_SHIFT: begin
          r_mag  <= {w_ob, r_mag[N-1:1]};
          r_sr   <= {1'b0, r_sr[N-1:1]};
          r_seen <= r_seen | (r_sign & r_sr[0]);
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          // Accept with a waiting word is covered above; here the consumer may release to IDLE.
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_sign  = r_sign;
  assign io_bus.out_mag   = r_mag;

endmodule
